tanimoto_comparator_wrapper: RTL and testbench

Thresholding stage of the Tanimoto similarity pipeline (RTL module name `comparator_wrapper`). It takes popcounts of vector A, vector B and A AND B and flags whether the Tanimoto coefficient C/(A+B−C) reaches a programmable threshold. It uses a per-sum lookup table of minimum intersection counts, rebuilt by an internal load FSM whenever the threshold is written, so the datapath is compare-only. It sits downstream of the popcount units and feeds the result collector.

---
 rtl/tanimoto_comparator_wrapper_pkg.sv | 19 +
 rtl/tanimoto_comparator_wrapper_min_c_table.sv | 24 ++
 rtl/tanimoto_comparator_wrapper.sv | 134 +++++++++++++
 tb/tb_tanimoto_comparator_wrapper.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tanimoto_comparator_wrapper_pkg.sv
// Shared width helpers and load-FSM state encoding for the Tanimoto
// threshold comparator.
package tanimoto_comparator_wrapper_pkg;

  function automatic int cnt_width(input int vector_width);
    return $clog2(vector_width);
  endfunction

  function automatic int sum_width(input int vector_width);
    return $clog2(2 * vector_width + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

endpackage

// File: rtl/tanimoto_comparator_wrapper_min_c_table.sv
// Minimum-intersection lookup table indexed by A+B: one synchronous write
// port, one synchronous read port.
module tanimoto_comparator_wrapper_min_c_table #(
  parameter int DEPTH = 71,
  parameter int AW    = 7,
  parameter int DW    = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Read returns the pre-write contents when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tanimoto_comparator_wrapper.sv
// Tanimoto threshold stage: a load FSM precomputes minC[A+B] whenever the
// threshold changes, so the streaming path is a single table compare.
//
//   state | meaning
//   IDLE  | after reset, table invalid, inputs dropped
//   LOAD  | walking s = 0..2*VECTOR_WIDTH, writing minC[s]
//   READY | table valid, inputs accepted
module tanimoto_comparator_wrapper
  import tanimoto_comparator_wrapper_pkg::*;
#(
  parameter  int VECTOR_WIDTH = 35,
  parameter  int BUS_WIDTH    = 20,
  localparam int CNT_WIDTH    = cnt_width(VECTOR_WIDTH),
  localparam int SUM_WIDTH    = sum_width(VECTOR_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] i_CntA,
  input  logic [CNT_WIDTH-1:0] i_CntB,
  input  logic [CNT_WIDTH-1:0] i_CntC,
  input  logic                 i_WrThreshold,
  input  logic [CNT_WIDTH-1:0] i_Threshold,
  input  logic                 i_Valid,
  output logic                 o_Valid,
  output logic                 o_Ready,
  output logic                 o_Dout
);

  localparam int TBL_DEPTH = 2 * VECTOR_WIDTH + 1;
  localparam int DW        = CNT_WIDTH + 1;
  localparam int PW        = CNT_WIDTH + SUM_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] LAST_S = SUM_WIDTH'(2 * VECTOR_WIDTH);

  if (BUS_WIDTH < 1) begin : g_bus_width_check
    $error("BUS_WIDTH must be positive");
  end

  state_e               state;
  logic [CNT_WIDTH-1:0] th_q;
  logic [SUM_WIDTH-1:0] s_q;
  logic [DW-1:0]        c_q;
  logic [SUM_WIDTH-1:0] diff;
  logic [PW-1:0]        lhs;
  logic [PW-1:0]        rhs;
  logic                 step_pass;
  logic                 wr_en;

  // c never exceeds s during the walk, so s - c cannot wrap.
  assign diff      = s_q - SUM_WIDTH'(c_q);
  assign lhs       = PW'(c_q) << CNT_WIDTH;
  assign rhs       = PW'(th_q) * PW'(diff);
  assign step_pass = (lhs >= rhs);
  assign wr_en     = (state == LOAD) && step_pass && !i_WrThreshold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      th_q    <= '0;
      s_q     <= '0;
      c_q     <= '0;
      o_Ready <= 1'b0;
    end else if (i_WrThreshold) begin
      state   <= LOAD;
      th_q    <= i_Threshold;
      s_q     <= '0;
      c_q     <= '0;
      o_Ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (step_pass) begin
            if (s_q == LAST_S) begin
              state   <= READY;
              o_Ready <= 1'b1;
            end else begin
              s_q <= s_q + SUM_WIDTH'(1);
            end
          end else begin
            c_q <= c_q + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  logic [CNT_WIDTH-1:0] a1, b1, c1, s2_c;
  logic                 s1_valid, s2_valid, s2_empty;
  logic [SUM_WIDTH-1:0] rd_addr;
  logic [DW-1:0]        rd_data;

  assign rd_addr = SUM_WIDTH'(a1) + SUM_WIDTH'(b1);

  tanimoto_comparator_wrapper_min_c_table #(
    .DEPTH (TBL_DEPTH),
    .AW    (SUM_WIDTH),
    .DW    (DW)
  ) u_min_c_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (s_q),
    .wr_data (c_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Empty union (A+B == C) must fail even though minC[0] is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1       <= '0;
      b1       <= '0;
      c1       <= '0;
      s1_valid <= 1'b0;
      s2_c     <= '0;
      s2_empty <= 1'b0;
      s2_valid <= 1'b0;
      o_Valid  <= 1'b0;
      o_Dout   <= 1'b0;
    end else begin
      s1_valid <= i_Valid && o_Ready;
      if (i_Valid && o_Ready) begin
        a1 <= i_CntA;
        b1 <= i_CntB;
        c1 <= i_CntC;
      end
      s2_valid <= s1_valid;
      s2_c     <= c1;
      s2_empty <= (rd_addr == SUM_WIDTH'(c1));
      o_Valid  <= s2_valid;
      o_Dout   <= s2_valid && !s2_empty && (DW'(s2_c) >= rd_data);
    end
  end

endmodule

// File: tb/tb_tanimoto_comparator_wrapper.sv
// Scoreboard bench: accepted inputs push an expected result computed from the
// Tanimoto ratio directly; a negedge monitor pops and compares on o_Valid.
module tb_tanimoto_comparator_wrapper;

  localparam int VW = 35;
  localparam int CW = $clog2(VW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] i_CntA = '0, i_CntB = '0, i_CntC = '0, i_Threshold = '0;
  logic          i_WrThreshold = 1'b0, i_Valid = 1'b0;
  logic          o_Valid, o_Ready, o_Dout;

  tanimoto_comparator_wrapper #(.VECTOR_WIDTH(VW), .BUS_WIDTH(20)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_CntA        (i_CntA),
    .i_CntB        (i_CntB),
    .i_CntC        (i_CntC),
    .i_WrThreshold (i_WrThreshold),
    .i_Threshold   (i_Threshold),
    .i_Valid       (i_Valid),
    .o_Valid       (o_Valid),
    .o_Ready       (o_Ready),
    .o_Dout        (o_Dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit exp;
    int cyc;
    int a, b, c;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_cmp = 0, n_fail = 0, cyc = 0, th_model = 0;

  int va[8] = '{33, 8, 15, 35, 8, 35, 24, 0};
  int vb[8] = '{17, 19, 32, 17, 5, 35, 0, 0};
  int vc[8] = '{17, 6, 12, 17, 1, 35, 0, 0};
  bit ve[8] = '{1, 0, 0, 1, 0, 1, 0, 0};

  function automatic bit ref_pass(int th, int a, int b, int c);
    int uni;
    uni = a + b - c;
    if (uni <= 0) return 1'b0;
    return (c * (1 << CW)) >= (th * uni);
  endfunction

  // Table build writes 2*VW+1 entries and advances c up to minC at the top sum.
  function automatic int ref_load_cycles(int th);
    for (int c = 0; c <= 2 * VW; c++)
      if (c * (1 << CW) >= th * (2 * VW - c)) return 2 * VW + 1 + c;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    sb_entry_t e;
    cyc++;
    if (rst) begin
      sb.delete();
      th_model = 0;
    end else begin
      if (i_Valid && o_Ready) begin
        e.exp = ref_pass(th_model, i_CntA, i_CntB, i_CntC);
        e.cyc = cyc;
        e.a = i_CntA; e.b = i_CntB; e.c = i_CntC;
        sb.push_back(e);
      end
      if (i_WrThreshold) th_model = i_Threshold;
    end
  end

  always @(negedge clk) begin
    sb_entry_t e;
    if (o_Valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("dout(%0d,%0d,%0d)", e.a, e.b, e.c), o_Dout, e.exp);
        check("latency", cyc - e.cyc, 2);
      end
    end
  end

  task automatic drive(input int a, input int b, input int c, input bit v);
    @(negedge clk);
    i_CntA = CW'(a); i_CntB = CW'(b); i_CntC = CW'(c); i_Valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1'b0);
  endtask

  task automatic drive_rand;
    int a, b, c;
    a = $urandom_range(0, VW);
    b = $urandom_range(0, VW);
    c = $urandom_range(0, (a < b) ? a : b);
    drive(a, b, c, $urandom_range(0, 3) != 0);
  endtask

  // Issues a threshold write; optionally keeps random valids going during LOAD.
  task automatic write_th(input int th, input bit noise, input bit wait_done);
    int j;
    @(negedge clk);
    i_WrThreshold = 1'b1;
    i_Threshold   = CW'(th);
    @(negedge clk);
    i_WrThreshold = 1'b0;
    if (noise) drive_rand_now();
    else i_Valid = 1'b0;
    check("ready_drop", o_Ready, 0);
    if (wait_done) begin
      j = 0;
      while (!o_Ready && j < 120) begin
        if (noise) drive_rand();
        else @(negedge clk);
        j++;
      end
      check($sformatf("load_cycles(th=%0d)", th), j, ref_load_cycles(th));
      i_Valid = 1'b0;
    end
  endtask

  task automatic drive_rand_now;
    int a, b, c;
    a = $urandom_range(0, VW);
    b = $urandom_range(0, VW);
    c = $urandom_range(0, (a < b) ? a : b);
    i_CntA = CW'(a); i_CntB = CW'(b); i_CntC = CW'(c); i_Valid = 1'b1;
  endtask

  task automatic run_vectors(input bit gap);
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], vc[i], 1'b1);
      if (gap) drive(0, 0, 0, 1'b0);
    end
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) drive_rand();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", o_Valid, 0);
    check("rst_dout", o_Dout, 0);
    check("rst_ready", o_Ready, 0);
    rst = 1'b0;

    // No threshold written: everything offered is dropped.
    for (int i = 0; i < 40; i++) drive(5, 5, 5, 1'b1);
    idle(4);
    check("idle_ready", o_Ready, 0);

    // Reference sequence at Th=25, including the minC boundaries at sums 33 and 70.
    write_th(25, 1'b0, 1'b1);
    run_vectors(1'b0);
    drive(20, 13, 10, 1'b1);
    drive(20, 13, 9, 1'b1);
    drive(35, 35, 20, 1'b1);
    drive(35, 35, 19, 1'b1);
    run_rand(40);

    // Rewrite mid-stream with valids flowing through LOAD, then replay with gaps.
    drive(33, 17, 17, 1'b1);
    write_th(25, 1'b1, 1'b1);
    run_vectors(1'b1);
    idle(4);

    write_th(0, 1'b0, 1'b1);
    run_vectors(1'b0);
    run_rand(40);
    idle(4);

    write_th(63, 1'b0, 1'b1);
    drive(20, 20, 20, 1'b1);
    drive(20, 20, 19, 1'b1);
    run_vectors(1'b0);
    run_rand(40);

    for (int k = 0; k < 4; k++) begin
      write_th($urandom_range(0, (1 << CW) - 1), 1'b1, 1'b1);
      run_rand(60);
    end
    idle(4);

    // Reset in LOAD with one result still in flight.
    run_vectors(1'b0);
    drive(35, 35, 35, 1'b1);
    write_th(25, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midload_valid", o_Valid, 0);
    check("midload_dout", o_Dout, 0);
    check("midload_ready", o_Ready, 0);
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 120; i++) drive(10, 10, 10, (i % 3) == 0);
    check("postrst_ready", o_Ready, 0);
    write_th(25, 1'b0, 1'b1);
    run_vectors(1'b0);
    run_rand(30);
    idle(6);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
